dctq_rle_encoder: RTL and testbench
===================================

# dctq_rle_encoder

Receiving end of the quantized-DCT output stream (`dctq`, `dctq_valid`, `addr`, `hold`). Captures each 8x8 block of 9-bit signed quantized coefficients, delivered in raster order, into a ping-pong buffer. Re-reads each block in zigzag order and emits run-length tokens (run of zeros, level) with an end-of-block marker to the downstream entropy coder. Drives `hold` back to the DCTQ controller when no buffer bank is free.

## Interface

- Parameters:
  - `DW`, default 9: coefficient width, two's complement.
- Ports:
  - `clk` in 1: single clock.
  - `reset_n` in 1: reset, synchronous and active-low.
  - `dctq` in DW: quantized coefficient, signed.
  - `dctq_valid` in 1: `dctq`/`addr` valid this cycle.
  - `addr` in 6: raster index of the coefficient (row*8+col).
  - `hold` out 1: registered; 1 = no bank free, upstream must not start a new block.
  - `rle_valid` out 1: token valid.
  - `rle_run` out 6: number of zero AC coefficients preceding `rle_level`.
  - `rle_level` out DW: coefficient value, signed.
  - `rle_last` out 1: token is the end-of-block marker.
  - `rle_ready` in 1: downstream accepts the token when `rle_valid & rle_ready`.
  - `overrun` out 1: sticky; set on any `dctq_valid` sampled while `hold`=1.

## Operation

- Write side:
  - Write bank pointer `wb` and 6-bit write count `wcnt`.
  - On `dctq_valid & !hold`: write `dctq` into bank `wb` at `addr`, and increment `wcnt`.
  - The 64th write (`wcnt`==63) marks bank `wb` full, toggles `wb`, and clears `wcnt`.
  - Duplicate or missing addresses are not checked; a block is complete after exactly 64 accepted writes.
  - `dctq_valid` while `hold`=1: the write is dropped and `overrun` is set. It clears only on reset.
- Hold:
  - `hold` is registered.
  - It is 1 in the cycle after the new write bank is found to be full, i.e. both banks are full.
  - It returns to 0 the cycle after the read side releases a bank.
  - If a block completes in the same cycle a bank is released, `hold` stays 0.
- Read side FSM:
  - IDLE: wait for the read bank `rb` to be full, then go to SCAN with `k`=0 and `run`=0.
  - SCAN: issue synchronous read of `zz(k)` from bank `rb`, one per cycle. When the data returns:
    - At `k`=0 (DC): emit token run=0, level=DC, always, even when zero.
    - Nonzero AC: emit (`run`, level) and clear `run`.
    - Zero AC: `run`++, no token. `run` is at most 62, so it never wraps.
  - After `k`=63 is evaluated, go to EOB.
  - EOB: emit run=0, level=0, last=1. This happens always, even when coefficient 63 was nonzero. On acceptance: release bank `rb`, toggle `rb`, go to IDLE.
- Output register:
  - Holds the token stable while `rle_valid & !rle_ready`.
  - A token pending and not accepted stalls the SCAN pipeline: no `k` advance, and the read address is re-issued.
- Reset (`reset_n`=0 at a `clk` edge): at any point, including mid-block, the following return to their reset values:
  - `wb`=0, `rb`=0, `wcnt`=0; both bank-full flags 0; FSM=IDLE; `k`=0, `run`=0.
  - Outputs: `hold`=0, `rle_valid`=0, `rle_run`=0, `rle_level`=0, `rle_last`=0, `overrun`=0.
  - RAM contents are not reset.

## Timing

- The 64th write is sampled at edge T.
  - Bank-full flag at T+1; read of `zz(0)` issued at T+1; data at T+2.
  - DC token `rle_valid` at edge T+3.
- With `rle_ready`=1 throughout, a block produces its tokens over 64 evaluation cycles plus the EOB cycle.
  - Next IDLE→SCAN transition is at the earliest the cycle after EOB acceptance.
- `rle_valid` changes only on `clk` edges. Once asserted it is deasserted only after acceptance, or by reset.
- Writes into bank `wb` and reads from bank `rb` may occur in the same cycle; the banks are always different when both are active.

## Structure

- Package `dctq_rle_pkg`:
  - `DW` default.
  - FSM state enum (IDLE, SCAN, EOB).
  - Token struct {run[5:0], level[DW-1:0], last}.
  - `zz(k)` function: the 64-entry zigzag table mapping scan index to raster address (0,1,8,16,9,2,3,10,...,63).
- Sub-module `dctq_pingpong_ram`: 2x64xDW, one write port, one synchronous read port, bank select bit on each port.
- Top holds the write counter, hold logic, FSM, run counter and output register.

## Test plan

- All-zero block, `rle_ready`=1 → exactly two tokens: (0,0,last=0) then (0,0,last=1). DC token at T+3.
- Raster `addr`0=12, `addr`1=-3, `addr`8=5, rest 0 → tokens (0,12), (0,-3), (0,5), EOB.
- Only `addr`63=-1 → (0,0), (62,-1), EOB; checks maximum run.
- Three back-to-back blocks, `rle_ready`=0 for 200 cycles:
  - `hold`=1 the cycle after the second block completes; no tokens accepted.
  - After `rle_ready`=1 and the first EOB is accepted, `hold`=0 the next cycle.
  - Token order is preserved across all blocks.
- `dctq_valid` driven while `hold`=1 → data dropped, `overrun`=1 and sticky.
- `reset_n`=0 for one cycle mid-SCAN with a token pending → all outputs 0 the next cycle; a fresh block afterwards encodes correctly.

Source files
------------

// File: rtl/dctq_rle_pkg.sv
// Shared types and the zigzag scan table for the DCTQ run-length encoder.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package dctq_rle_pkg;

  localparam int DW_DEFAULT = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EOB
  } state_t;

  typedef struct packed {
    logic [5:0]            run;
    logic [DW_DEFAULT-1:0] level;
    logic                  last;
  } token_t;

  // Scan index -> raster address (row*8+col) for the standard 8x8 zigzag.
  localparam logic [5:0] ZZ_TBL [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz(input logic [5:0] k);
    return ZZ_TBL[k];
  endfunction

endpackage

// File: rtl/dctq_pingpong_ram.sv
// Two 64-entry coefficient banks: one write port, one synchronous read port.
// Latency: read data valid one clock after the address is presented.
// Backpressure: none; caller re-presents the address to re-read.
module dctq_pingpong_ram #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [5:0]    wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_bank,
  input  logic [5:0]    rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [128];
  logic [DW-1:0] rd_dat_q;

  // Write port: bank bit is the MSB of the flat address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_dat;
    end
  end

  // Synchronous read port, unconditionally re-read every cycle.
  always_ff @(posedge clk) begin
    rd_dat_q <= mem[{rd_bank, rd_addr}];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/dctq_rle_encoder.sv
// Captures raster-order 8x8 quantized blocks into ping-pong banks, emits zigzag RLE tokens + EOB.
// Latency: DC token valid 3 clocks after the 64th coefficient write; one evaluation per clock.
// Backpressure: pending unaccepted token stalls the scan; hold asserted when both banks are full.
module dctq_rle_encoder
  import dctq_rle_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] dctq,
  input  logic          dctq_valid,
  input  logic [5:0]    addr,
  output logic          hold,
  output logic          rle_valid,
  output logic [5:0]    rle_run,
  output logic [DW-1:0] rle_level,
  output logic          rle_last,
  input  logic          rle_ready,
  output logic          overrun
);

  // Write side state
  logic          wb_q, wb_d;
  logic [5:0]    wcnt_q, wcnt_d;
  logic [1:0]    full_q, full_d, full_set, full_clr;
  logic          hold_q, hold_d;
  logic          overrun_q, overrun_d;
  logic          wr_en;

  // Read side state: k is the issue index, ek/ev the index/valid of the word being evaluated
  state_t        state_q, state_d;
  logic          rb_q, rb_d;
  logic [6:0]    k_q, k_d;
  logic [5:0]    run_q, run_d;
  logic          ev_q, ev_d;
  logic [5:0]    ek_q, ek_d;

  // Output register
  logic          rle_valid_q, rle_valid_d;
  logic [5:0]    rle_run_q, rle_run_d;
  logic [DW-1:0] rle_level_q, rle_level_d;
  logic          rle_last_q, rle_last_d;

  logic          stall;
  logic [5:0]    rd_addr;
  logic [DW-1:0] coef;

  dctq_pingpong_ram #(.DW(DW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (wb_q),
    .wr_addr (addr),
    .wr_dat  (dctq),
    .rd_bank (rb_q),
    .rd_addr (rd_addr),
    .rd_dat  (coef)
  );

  // Write counter, bank completion, registered hold and sticky overrun.
  always_comb begin
    wr_en     = dctq_valid & ~hold_q;
    wb_d      = wb_q;
    wcnt_d    = wcnt_q;
    full_set  = 2'b00;
    overrun_d = overrun_q | (dctq_valid & hold_q);
    if (wr_en) begin
      if (wcnt_q == 6'd63) begin
        full_set[wb_q] = 1'b1;
        wb_d           = ~wb_q;
        wcnt_d         = 6'd0;
      end else begin
        wcnt_d = wcnt_q + 6'd1;
      end
    end
    full_d = (full_q | full_set) & ~full_clr;
    // Look ahead at next-state flags so no write can slip into a full bank.
    hold_d = full_d[wb_d];
  end

  // Scan FSM, run counter and token register; a pending token freezes the pipeline.
  always_comb begin
    state_d     = state_q;
    rb_d        = rb_q;
    k_d         = k_q;
    run_d       = run_q;
    ev_d        = ev_q;
    ek_d        = ek_q;
    full_clr    = 2'b00;
    rle_valid_d = rle_valid_q & ~rle_ready;
    rle_run_d   = rle_run_q;
    rle_level_d = rle_level_q;
    rle_last_d  = rle_last_q;
    stall       = rle_valid_q & ~rle_ready;
    // While stalled, re-read the word under evaluation so the RAM output stays on it.
    rd_addr     = stall ? zz(ek_q) : zz(k_q[5:0]);

    case (state_q)
      S_IDLE: begin
        if (full_q[rb_q]) begin
          state_d = S_SCAN;
          k_d     = 7'd0;
          run_d   = 6'd0;
          ev_d    = 1'b0;
        end
      end
      S_SCAN: begin
        if (!stall) begin
          if (!k_q[6]) begin
            ev_d = 1'b1;
            ek_d = k_q[5:0];
            k_d  = k_q + 7'd1;
          end else begin
            ev_d = 1'b0;
          end
          if (ev_q) begin
            // DC always emits; run is 0 there since it was cleared on scan entry.
            if (ek_q == 6'd0 || coef != '0) begin
              rle_valid_d = 1'b1;
              rle_run_d   = run_q;
              rle_level_d = coef;
              rle_last_d  = 1'b0;
              run_d       = 6'd0;
            end else begin
              run_d = run_q + 6'd1;
            end
            if (ek_q == 6'd63) begin
              state_d = S_EOB;
            end
          end
        end
      end
      S_EOB: begin
        if (rle_valid_q && rle_last_q) begin
          if (rle_ready) begin
            full_clr[rb_q] = 1'b1;
            rb_d           = ~rb_q;
            state_d        = S_IDLE;
          end
        end else if (!stall) begin
          rle_valid_d = 1'b1;
          rle_run_d   = 6'd0;
          rle_level_d = '0;
          rle_last_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; RAM contents are left alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_q        <= 1'b0;
      wcnt_q      <= 6'd0;
      full_q      <= 2'b00;
      hold_q      <= 1'b0;
      overrun_q   <= 1'b0;
      state_q     <= S_IDLE;
      rb_q        <= 1'b0;
      k_q         <= 7'd0;
      run_q       <= 6'd0;
      ev_q        <= 1'b0;
      ek_q        <= 6'd0;
      rle_valid_q <= 1'b0;
      rle_run_q   <= 6'd0;
      rle_level_q <= '0;
      rle_last_q  <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      wcnt_q      <= wcnt_d;
      full_q      <= full_d;
      hold_q      <= hold_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
      rb_q        <= rb_d;
      k_q         <= k_d;
      run_q       <= run_d;
      ev_q        <= ev_d;
      ek_q        <= ek_d;
      rle_valid_q <= rle_valid_d;
      rle_run_q   <= rle_run_d;
      rle_level_q <= rle_level_d;
      rle_last_q  <= rle_last_d;
    end
  end

  assign hold      = hold_q;
  assign overrun   = overrun_q;
  assign rle_valid = rle_valid_q;
  assign rle_run   = rle_run_q;
  assign rle_level = rle_level_q;
  assign rle_last  = rle_last_q;

endmodule

// File: tb/tb_dctq_rle_encoder.sv
// Self-checking bench for dctq_rle_encoder: directed blocks, backpressure, overrun, reset, random blocks.
// Latency: checks DC token timing against the 64th write edge.
// Backpressure: rle_ready driven constant-low, constant-high or random per phase.
module tb_dctq_rle_encoder;

  logic       clk;
  logic       reset_n;
  logic [8:0] dctq;
  logic       dctq_valid;
  logic [5:0] addr;
  logic       hold;
  logic       rle_valid;
  logic [5:0] rle_run;
  logic [8:0] rle_level;
  logic       rle_last;
  logic       rle_ready;
  logic       overrun;

  int          tests = 0;
  int          fails = 0;
  int          rdy_mode = 0;
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  logic [8:0]  cur_blk[64];
  int          zz_ord[64];

  dctq_rle_encoder #(.DW(9)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dctq       (dctq),
    .dctq_valid (dctq_valid),
    .addr       (addr),
    .hold       (hold),
    .rle_valid  (rle_valid),
    .rle_run    (rle_run),
    .rle_level  (rle_level),
    .rle_last   (rle_last),
    .rle_ready  (rle_ready),
    .overrun    (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready: 0 = never, 1 = always, otherwise random each cycle.
  initial begin
    rle_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       rle_ready = 1'b0;
        1:       rle_ready = 1'b1;
        default: rle_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Record every token that is handed over at the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && rle_valid && rle_ready) got.push_back({rle_last, rle_run, rle_level});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Zigzag order built by walking anti-diagonals, alternating direction.
  task automatic build_zz();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz_ord[n] = r * 8 + (s - r);
          n++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz_ord[n] = r * 8 + (s - r);
          n++;
        end
      end
    end
  endtask

  // Reference encoding of cur_blk appended to the expected token list.
  task automatic model_block();
    int run = 0;
    for (int k = 0; k < 64; k++) begin
      logic [8:0] v = cur_blk[zz_ord[k]];
      if (k == 0) begin
        exp_q.push_back({1'b0, 6'd0, v});
      end else if (v != 9'd0) begin
        exp_q.push_back({1'b0, 6'(run), v});
        run = 0;
      end else begin
        run++;
      end
    end
    exp_q.push_back({1'b1, 6'd0, 9'd0});
  endtask

  task automatic clear_blk();
    for (int a = 0; a < 64; a++) cur_blk[a] = 9'd0;
  endtask

  task automatic gen_rand();
    for (int a = 0; a < 64; a++)
      cur_blk[a] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'd0;
  endtask

  // Streams cur_blk in raster order, honouring hold; returns 1ns after the 64th write edge.
  task automatic write_block();
    for (int a = 0; a < 64; a++) begin
      int g = 0;
      while (hold === 1'b1 && g < 3000) begin
        @(posedge clk);
        #1;
        g++;
      end
      if (g >= 3000) begin
        fails++;
        $error("FAIL hold_timeout: observed hold=1 for %0d cycles expected release", g);
      end
      dctq_valid = 1'b1;
      addr       = 6'(a);
      dctq       = cur_blk[a];
      @(posedge clk);
      #1;
    end
    dctq_valid = 1'b0;
  endtask

  task automatic check_tokens(input string tag);
    int g = 0;
    int n;
    while (got.size() < exp_q.size() && g < 5000) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk($sformatf("%s_count", tag), got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_tok%0d", tag, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int g;
    build_zz();
    reset_n    = 1'b0;
    dctq       = 9'd0;
    dctq_valid = 1'b0;
    addr       = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", hold, 0);
    chk("rst_valid", rle_valid, 0);
    chk("rst_run", rle_run, 0);
    chk("rst_level", rle_level, 0);
    chk("rst_last", rle_last, 0);
    chk("rst_overrun", overrun, 0);
    reset_n = 1'b1;

    // All-zero block: DC token appears exactly at T+3.
    rdy_mode = 1;
    clear_blk();
    exp_q.push_back({1'b0, 6'd0, 9'd0});
    exp_q.push_back({1'b1, 6'd0, 9'd0});
    write_block();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("dc_T2_not_valid", rle_valid, 0);
    @(posedge clk);
    #1;
    chk("dc_T3_valid", rle_valid, 1);
    chk("dc_T3_token", {rle_last, rle_run, rle_level}, {1'b0, 6'd0, 9'd0});
    check_tokens("zero");

    // Three low-frequency coefficients.
    clear_blk();
    cur_blk[0] = 9'd12;
    cur_blk[1] = 9'h1FD;
    cur_blk[8] = 9'd5;
    exp_q.push_back({1'b0, 6'd0, 9'd12});
    exp_q.push_back({1'b0, 6'd0, 9'h1FD});
    exp_q.push_back({1'b0, 6'd0, 9'd5});
    exp_q.push_back({1'b1, 6'd0, 9'd0});
    write_block();
    check_tokens("lowfreq");

    // Only the last coefficient: longest possible run.
    clear_blk();
    cur_blk[63] = 9'h1FF;
    exp_q.push_back({1'b0, 6'd0, 9'd0});
    exp_q.push_back({1'b0, 6'd62, 9'h1FF});
    exp_q.push_back({1'b1, 6'd0, 9'd0});
    write_block();
    check_tokens("maxrun");

    // Back-to-back blocks against a stalled consumer.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    gen_rand();
    model_block();
    write_block();
    @(negedge clk);
    chk("hold_after_b1", hold, 0);
    gen_rand();
    model_block();
    write_block();
    @(negedge clk);
    chk("hold_after_b2", hold, 1);
    chk("none_accepted_b2", got.size(), 0);
    @(posedge clk);
    #1;
    chk("overrun_pre", overrun, 0);
    dctq_valid = 1'b1;
    addr       = 6'd0;
    dctq       = 9'h0AA;
    @(posedge clk);
    #1;
    dctq_valid = 1'b0;
    chk("overrun_set", overrun, 1);
    repeat (200) @(posedge clk);
    #1;
    chk("none_accepted_200", got.size(), 0);
    chk("hold_stalled", hold, 1);
    chk("overrun_sticky", overrun, 1);
    rdy_mode = 1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(rle_valid && rle_ready && rle_last) && g < 2000);
    chk("eob1_seen", (g < 2000), 1);
    chk("hold_before_release", hold, 1);
    @(negedge clk);
    chk("hold_after_release", hold, 0);
    gen_rand();
    model_block();
    write_block();
    check_tokens("b2b");

    // Random blocks with random backpressure.
    rdy_mode = 2;
    for (int b = 0; b < 4; b++) begin
      gen_rand();
      model_block();
      write_block();
    end
    check_tokens("rand");

    // Reset while a token is pending mid-scan.
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    gen_rand();
    cur_blk[0] = 9'd5;
    write_block();
    g = 0;
    while (rle_valid !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("pending_seen", rle_valid, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("mid_rst_hold", hold, 0);
    chk("mid_rst_valid", rle_valid, 0);
    chk("mid_rst_run", rle_run, 0);
    chk("mid_rst_level", rle_level, 0);
    chk("mid_rst_last", rle_last, 0);
    chk("mid_rst_overrun", overrun, 0);
    got.delete();
    exp_q.delete();
    rdy_mode = 1;
    gen_rand();
    model_block();
    write_block();
    check_tokens("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
